// File: rtl/core_pwr_pkg.sv
// Shared types and helpers for the per-core power controller.
// State encodings are visible on state_o, so their values are fixed.
package core_pwr_pkg;

    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_GATED = 3'd3,
        ST_WAKE  = 3'd4
    } core_state_e;

    localparam int unsigned STATE_W = 3;

    // Bits needed to hold values 0..max_val; never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/core_pwr_fsm.sv
// Single-core sleep/wake sequencer with idle, drain and wake timers,
// a saturating gated-cycle counter and a sticky drain-timeout flag.
module core_pwr_fsm
    import core_pwr_pkg::*;
#(
    parameter int unsigned IDLE_CYCLES   = 4,
    parameter int unsigned DRAIN_TIMEOUT = 256,
    parameter int unsigned WAKE_CYCLES   = 2,
    parameter int unsigned CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fetch_enable_i,
    input  logic             boot_en_i,
    input  logic             sleep_req_i,
    input  logic             wake_i,
    input  logic             core_busy_i,
    input  logic             cnt_clr_i,
    output logic             clk_en_o,
    output logic             active_d_o,
    output core_state_e      state_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] cnt_o
);

    localparam int unsigned IDLE_W  = cnt_width(IDLE_CYCLES);
    localparam int unsigned DRAIN_W = cnt_width(DRAIN_TIMEOUT);
    localparam int unsigned WAKE_W  = cnt_width(WAKE_CYCLES);

    core_state_e        state_q, state_d;
    logic [IDLE_W-1:0]  idle_q, idle_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic [WAKE_W-1:0]  wake_q, wake_d;
    logic               timeout_set;
    logic               timeout_q;
    logic               clk_en_q;
    logic [CNT_W-1:0]   gated_cnt_q;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        idle_d      = '0;
        drain_d     = '0;
        wake_d      = '0;
        timeout_set = 1'b0;
        unique case (state_q)
            ST_OFF: begin
                if (fetch_enable_i && boot_en_i) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (sleep_req_i && !wake_i) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Timers only advance here, so each DRAIN entry starts both from zero.
                idle_d  = core_busy_i ? '0 : idle_q + 1'b1;
                drain_d = drain_q + 1'b1;
                if (wake_i || !sleep_req_i) begin
                    state_d = ST_RUN;
                end else if (idle_d == IDLE_W'(IDLE_CYCLES)) begin
                    state_d = ST_GATED;
                end else if (drain_d == DRAIN_W'(DRAIN_TIMEOUT)) begin
                    state_d     = ST_RUN;
                    timeout_set = 1'b1;
                end
            end
            ST_GATED: begin
                if (wake_i) state_d = ST_WAKE;
            end
            ST_WAKE: begin
                wake_d = wake_q + 1'b1;
                if (wake_d == WAKE_W'(WAKE_CYCLES)) state_d = ST_RUN;
            end
            default: state_d = ST_OFF;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_OFF;
            idle_q      <= '0;
            drain_q     <= '0;
            wake_q      <= '0;
            clk_en_q    <= 1'b1;
            timeout_q   <= 1'b0;
            gated_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            idle_q   <= idle_d;
            drain_q  <= drain_d;
            wake_q   <= wake_d;
            clk_en_q <= (state_d != ST_GATED);
            if (timeout_set) begin
                timeout_q <= 1'b1;
            end else if (cnt_clr_i) begin
                timeout_q <= 1'b0;
            end
            if (cnt_clr_i) begin
                gated_cnt_q <= '0;
            end else if (state_q == ST_GATED && gated_cnt_q != '1) begin
                gated_cnt_q <= gated_cnt_q + 1'b1;
            end
        end
    end

    assign clk_en_o   = clk_en_q;
    assign active_d_o = (state_d != ST_OFF);
    assign state_o    = state_q;
    assign timeout_o  = timeout_q;
    assign cnt_o      = gated_cnt_q;

endmodule

// File: rtl/core_pwr_ctrl.sv
// Per-core clock-gate and fetch-enable controller: one sequencer per core,
// global fetch-enable gating and a gated-cycle counter readout mux.
module core_pwr_ctrl
    import core_pwr_pkg::*;
#(
    parameter int unsigned NB_CORES      = 4,
    parameter int unsigned IDLE_CYCLES   = 4,
    parameter int unsigned DRAIN_TIMEOUT = 256,
    parameter int unsigned WAKE_CYCLES   = 2,
    parameter int unsigned CNT_W         = 32
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                fetch_enable_i,
    input  logic [NB_CORES-1:0]                 boot_en_i,
    input  logic [NB_CORES-1:0]                 sleep_req_i,
    input  logic [NB_CORES-1:0]                 wake_i,
    input  logic [NB_CORES-1:0]                 core_busy_i,
    input  logic [NB_CORES-1:0]                 cnt_clr_i,
    input  logic [cnt_width(NB_CORES-1)-1:0]    cnt_sel_i,
    output logic [NB_CORES-1:0]                 clk_en_o,
    output logic [NB_CORES-1:0]                 fetch_enable_o,
    output logic [STATE_W*NB_CORES-1:0]         state_o,
    output logic [NB_CORES-1:0]                 timeout_o,
    output logic [CNT_W-1:0]                    cnt_o
);

    localparam int unsigned SEL_W = cnt_width(NB_CORES - 1);

    core_state_e         core_state [NB_CORES];
    logic [CNT_W-1:0]    core_cnt   [NB_CORES];
    logic [NB_CORES-1:0] active_d;
    logic [NB_CORES-1:0] fetch_q;

    for (genvar k = 0; k < NB_CORES; k++) begin : g_core
        core_pwr_fsm #(
            .IDLE_CYCLES   (IDLE_CYCLES),
            .DRAIN_TIMEOUT (DRAIN_TIMEOUT),
            .WAKE_CYCLES   (WAKE_CYCLES),
            .CNT_W         (CNT_W)
        ) u_fsm (
            .clk            (clk),
            .rst            (rst),
            .fetch_enable_i (fetch_enable_i),
            .boot_en_i      (boot_en_i[k]),
            .sleep_req_i    (sleep_req_i[k]),
            .wake_i         (wake_i[k]),
            .core_busy_i    (core_busy_i[k]),
            .cnt_clr_i      (cnt_clr_i[k]),
            .clk_en_o       (clk_en_o[k]),
            .active_d_o     (active_d[k]),
            .state_o        (core_state[k]),
            .timeout_o      (timeout_o[k]),
            .cnt_o          (core_cnt[k])
        );
        assign state_o[STATE_W*k +: STATE_W] = core_state[k];
    end

    // Fetch stays asserted through GATED/WAKE; only OFF or a low pad enable drops it.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_q <= '0;
        end else begin
            fetch_q <= active_d & {NB_CORES{fetch_enable_i}};
        end
    end

    assign fetch_enable_o = fetch_q;

    always_comb begin
        cnt_o = '0;
        for (int k = 0; k < NB_CORES; k++) begin
            if (cnt_sel_i == SEL_W'(k)) cnt_o = core_cnt[k];
        end
    end

endmodule

// File: tb/tb_core_pwr_ctrl.sv
// Directed bench for core_pwr_ctrl: a vector table for the main sequencing
// plus hand-written drain-timeout and reset-while-gated sequences.
module tb_core_pwr_ctrl;

    logic        clk;
    logic        rst;
    logic        fetch_enable;
    logic [3:0]  boot_en, sleep_req, wake, core_busy, cnt_clr;
    logic [1:0]  cnt_sel;
    logic [3:0]  clk_en, fetch_en, timeout;
    logic [11:0] state;
    logic [31:0] cnt;

    logic [2:0]  sat_clk_en, sat_fetch_en, sat_timeout;
    logic [8:0]  sat_state;
    logic [3:0]  sat_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    core_pwr_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_enable_i (fetch_enable),
        .boot_en_i      (boot_en),
        .sleep_req_i    (sleep_req),
        .wake_i         (wake),
        .core_busy_i    (core_busy),
        .cnt_clr_i      (cnt_clr),
        .cnt_sel_i      (cnt_sel),
        .clk_en_o       (clk_en),
        .fetch_enable_o (fetch_en),
        .state_o        (state),
        .timeout_o      (timeout),
        .cnt_o          (cnt)
    );

    // Three cores with a 4-bit counter: exercises saturation and out-of-range select.
    core_pwr_ctrl #(.NB_CORES(3), .CNT_W(4)) dut_sat (
        .clk            (clk),
        .rst            (rst),
        .fetch_enable_i (fetch_enable),
        .boot_en_i      (boot_en[2:0]),
        .sleep_req_i    (sleep_req[2:0]),
        .wake_i         (wake[2:0]),
        .core_busy_i    (core_busy[2:0]),
        .cnt_clr_i      (cnt_clr[2:0]),
        .cnt_sel_i      (cnt_sel),
        .clk_en_o       (sat_clk_en),
        .fetch_enable_o (sat_fetch_en),
        .state_o        (sat_state),
        .timeout_o      (sat_timeout),
        .cnt_o          (sat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        fe;
        logic [3:0]  boot, sleep, wk, busy, clr;
        logic [1:0]  sel;
        int          cyc;
        logic [3:0]  x_ce, x_fe, x_to;
        logic [11:0] x_st;
        logic [31:0] x_cnt;
        logic [3:0]  x_sat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] x_ce, input logic [3:0] x_fe,
                             input logic [3:0] x_to, input logic [11:0] x_st,
                             input logic [31:0] x_cnt, input logic [3:0] x_sat);
        check({tag, ".clk_en"},    32'(clk_en),    32'(x_ce));
        check({tag, ".fetch_en"},  32'(fetch_en),  32'(x_fe));
        check({tag, ".timeout"},   32'(timeout),   32'(x_to));
        check({tag, ".state"},     32'(state),     32'(x_st));
        check({tag, ".cnt"},       cnt,            x_cnt);
        check({tag, ".sat_state"}, 32'(sat_state), 32'(x_st[8:0]));
        check({tag, ".sat_cnt"},   32'(sat_cnt),   32'(x_sat));
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic add(input logic fe, input logic [3:0] boot, input logic [3:0] sleep,
                       input logic [3:0] wk, input logic [3:0] busy, input logic [3:0] clr,
                       input logic [1:0] sel, input int cyc, input logic [3:0] x_ce,
                       input logic [3:0] x_fe, input logic [3:0] x_to, input logic [11:0] x_st,
                       input logic [31:0] x_cnt, input logic [3:0] x_sat);
        vec_t v;
        v.fe = fe;  v.boot = boot; v.sleep = sleep; v.wk = wk; v.busy = busy; v.clr = clr;
        v.sel = sel; v.cyc = cyc; v.x_ce = x_ce; v.x_fe = x_fe; v.x_to = x_to;
        v.x_st = x_st; v.x_cnt = x_cnt; v.x_sat = x_sat;
        vecs.push_back(v);
    endtask

    initial begin
        //  fe boot     sleep    wake     busy     clr     sel cyc  clk_en   fetch    tmo      state   cnt sat
        add(1, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 1,  4'b1111, 4'b0101, 4'b0000, 12'h041, 0,  0);
        add(1, 4'b0101, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 1,  4'b1111, 4'b0101, 4'b0000, 12'h042, 0,  0);
        add(1, 4'b0101, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 3,  4'b1111, 4'b0101, 4'b0000, 12'h042, 0,  0);
        add(1, 4'b0101, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 1,  4'b1110, 4'b0101, 4'b0000, 12'h043, 0,  0);
        add(1, 4'b0101, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 10, 4'b1110, 4'b0101, 4'b0000, 12'h043, 10, 10);
        add(1, 4'b0101, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 0, 1,  4'b1111, 4'b0101, 4'b0000, 12'h044, 11, 11);
        add(1, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 1,  4'b1111, 4'b0101, 4'b0000, 12'h044, 11, 11);
        add(1, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 1,  4'b1111, 4'b0101, 4'b0000, 12'h041, 11, 11);
        add(1, 4'b0101, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 1,  4'b1111, 4'b0101, 4'b0000, 12'h042, 11, 11);
        add(1, 4'b0101, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 3,  4'b1111, 4'b0101, 4'b0000, 12'h042, 11, 11);
        add(1, 4'b0101, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 0, 1,  4'b1111, 4'b0101, 4'b0000, 12'h041, 11, 11);
        add(1, 4'b0101, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 0, 1,  4'b1111, 4'b0101, 4'b0000, 12'h041, 11, 11);
        add(1, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 1,  4'b1111, 4'b0101, 4'b0000, 12'h041, 11, 11);
        add(1, 4'b0101, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 2,  4'b1111, 4'b0101, 4'b0000, 12'h042, 11, 11);
        add(1, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 1,  4'b1111, 4'b0101, 4'b0000, 12'h041, 11, 11);
        add(1, 4'b0101, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 3,  4'b1111, 4'b0101, 4'b0000, 12'h042, 11, 11);
        add(1, 4'b0101, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 0, 1,  4'b1111, 4'b0101, 4'b0000, 12'h042, 11, 11);
        add(1, 4'b0101, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 3,  4'b1111, 4'b0101, 4'b0000, 12'h042, 11, 11);
        add(1, 4'b0101, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 1,  4'b1110, 4'b0101, 4'b0000, 12'h043, 11, 11);
        add(1, 4'b0101, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 0, 1,  4'b1110, 4'b0101, 4'b0000, 12'h043, 0,  0);
        add(1, 4'b0101, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 20, 4'b1110, 4'b0101, 4'b0000, 12'h043, 20, 15);
        add(1, 4'b0101, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 3, 1,  4'b1110, 4'b0101, 4'b0000, 12'h043, 0,  0);
        add(1, 4'b0101, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 0, 1,  4'b1111, 4'b0101, 4'b0000, 12'h044, 22, 15);
        add(1, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 2,  4'b1111, 4'b0101, 4'b0000, 12'h041, 22, 15);
        add(0, 4'b0111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 1,  4'b1111, 4'b0000, 4'b0000, 12'h041, 22, 15);
        add(1, 4'b0111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 1,  4'b1111, 4'b0111, 4'b0000, 12'h049, 22, 15);
        add(1, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 1,  4'b1111, 4'b0111, 4'b0000, 12'h049, 22, 15);

        rst = 1'b1; fetch_enable = 1'b0; boot_en = '0; sleep_req = '0;
        wake = '0; core_busy = '0; cnt_clr = '0; cnt_sel = '0;
        step(2);
        check_all("reset", 4'b1111, 4'b0000, 4'b0000, 12'h000, 0, 0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            fetch_enable = vecs[i].fe;   boot_en   = vecs[i].boot;
            sleep_req    = vecs[i].sleep; wake     = vecs[i].wk;
            core_busy    = vecs[i].busy;  cnt_clr  = vecs[i].clr;
            cnt_sel      = vecs[i].sel;
            step(vecs[i].cyc);
            check_all($sformatf("v%0d", i), vecs[i].x_ce, vecs[i].x_fe, vecs[i].x_to,
                      vecs[i].x_st, vecs[i].x_cnt, vecs[i].x_sat);
        end

        // Core 2 drain timeout: busy alternates three low / three high so idle never reaches four.
        sleep_req = 4'b0100;
        step(1);
        check_all("tmo_entry", 4'b1111, 4'b0111, 4'b0000, 12'h089, 22, 15);
        for (int c = 1; c <= 255; c++) begin
            core_busy[2] = ((c - 1) / 3) % 2;
            step(1);
        end
        check_all("tmo_255", 4'b1111, 4'b0111, 4'b0000, 12'h089, 22, 15);
        core_busy[2] = 1'b1;
        step(1);
        check_all("tmo_256", 4'b1111, 4'b0111, 4'b0100, 12'h049, 22, 15);
        check("tmo_sat_flag", 32'(sat_timeout), 32'(3'b100));
        sleep_req = '0; core_busy = '0;
        step(1);
        check_all("tmo_sticky", 4'b1111, 4'b0111, 4'b0100, 12'h049, 22, 15);
        cnt_clr = 4'b0100;
        step(1);
        cnt_clr = '0;
        check_all("tmo_clr", 4'b1111, 4'b0111, 4'b0000, 12'h049, 22, 15);

        // Reset while core 0 is gated.
        sleep_req = 4'b0001;
        step(5);
        check_all("rst_pre_gated", 4'b1110, 4'b0111, 4'b0000, 12'h04B, 22, 15);
        step(3);
        check_all("rst_pre_cnt", 4'b1110, 4'b0111, 4'b0000, 12'h04B, 25, 15);
        rst = 1'b1;
        step(1);
        check_all("rst_gated", 4'b1111, 4'b0000, 4'b0000, 12'h000, 0, 0);
        rst = 1'b0; sleep_req = '0;
        step(1);
        check_all("rst_reboot", 4'b1111, 4'b0101, 4'b0000, 12'h041, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
